// File: rtl/jk_bank_pkg.sv
// Shared types and constants for the JK flop bank arbiter.
package jk_bank_pkg;

  localparam int OPCNT_W  = 16;
  // Wide enough to hold any legal index plus out-of-range values up to 63,
  // so "idx >= NUM_FF" can be evaluated even for NUM_FF=32.
  localparam int IDX_MAXW = 6;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_e;

  typedef struct packed {
    logic [IDX_MAXW-1:0] idx;
    jk_cmd_e             cmd;
  } jk_cmd_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [OPCNT_W-1:0] sat_inc(input logic [OPCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_ff_cell
  import jk_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  // JK state update: hold / reset / set / toggle.
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else begin
      case (jk_cmd_e'({j, k}))
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter feeding a one-deep command register that drives a
// bank of JK flops. Accept at edge E0, apply at edge E1.
// Note: rst_n is an active-high synchronous reset despite its name.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF  = 8,
  parameter int IDX_W   = (NUM_FF  > 1) ? $clog2(NUM_FF)  : 1,
  parameter int RID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  input  logic [NUM_REQ*2-1:0]     req_jk,
  output logic [NUM_FF-1:0]        q,
  output logic [NUM_FF-1:0]        q_bar,
  output logic                     grant_valid,
  output logic [RID_W-1:0]         grant_id,
  output logic                     err_oob,
  output logic [OPCNT_W-1:0]       op_count
);

  logic [IDX_W-1:0] idx_a [NUM_REQ];
  logic [1:0]       jk_a  [NUM_REQ];
  logic [RID_W-1:0] ptr, gnt_id;
  logic             gnt;
  jk_cmd_t          nxt_cmd, cmd_q;
  logic             cmd_v;
  logic [1:0]       cmd_jk;
  logic             in_rng;

  // Unpack per-requester fields so the arbiter can index them by id.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign idx_a[r] = req_idx[r*IDX_W +: IDX_W];
    assign jk_a[r]  = req_jk[r*2 +: 2];
  end

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  always_comb begin
    int               c;
    logic [RID_W-1:0] cid;
    req_ready = '0;
    gnt       = 1'b0;
    gnt_id    = '0;
    nxt_cmd   = '0;
    c         = 0;
    cid       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      cid = RID_W'(c);
      if (!rst_n && !gnt && req_valid[cid]) begin
        gnt            = 1'b1;
        gnt_id         = cid;
        req_ready[cid] = 1'b1;
        nxt_cmd.idx    = IDX_MAXW'(idx_a[cid]);
        nxt_cmd.cmd    = jk_cmd_e'(jk_a[cid]);
      end
    end
  end

  // Accept stage: latch the granted command, grant info and advance ptr.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr         <= '0;
      cmd_v       <= 1'b0;
      cmd_q       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      cmd_v       <= gnt;
      grant_valid <= gnt;
      if (gnt) begin
        cmd_q    <= nxt_cmd;
        grant_id <= gnt_id;
        ptr      <= (gnt_id == RID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  assign cmd_jk = cmd_q.cmd;
  assign in_rng = cmd_v && (cmd_q.idx < IDX_MAXW'(NUM_FF));

  // Apply stage: only the addressed flop sees the command, others hold.
  for (genvar f = 0; f < NUM_FF; f++) begin : g_bank
    logic hit;
    assign hit = cmd_v && (cmd_q.idx == IDX_MAXW'(f));
    jk_ff_cell u_cell (
      .clk   (clk),
      .rst   (rst_n),
      .j     (hit & cmd_jk[1]),
      .k     (hit & cmd_jk[0]),
      .q     (q[f]),
      .q_bar (q_bar[f])
    );
  end

  // Apply-stage status: out-of-range pulse and saturating op counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_oob  <= 1'b0;
      op_count <= '0;
    end else begin
      err_oob <= cmd_v & ~in_rng;
      if (in_rng) op_count <= sat_inc(op_count);
    end
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
Shares a bank of NUM_FF JK flip-flops between NUM_REQ requesters. Each requester issues {j,k} commands to one flop index over a valid/ready handshake. A round-robin arbiter accepts at most one command per cycle, registers it, and applies it to the addressed flop one edge later. The bank state (q, q_bar) is exported for downstream logic, together with grant and statistics outputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_FF, 8, number of JK flops in the bank (1..32; need not be a power of two)
IDX_W, $clog2(NUM_FF) (min 1), width of one flop index
RID_W, $clog2(NUM_REQ) (min 1), width of requester id

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_idx  in  NUM_REQ*IDX_W  target flop index; requester r uses slice [r*IDX_W +: IDX_W]
req_jk  in  NUM_REQ*2  command {j,k}; requester r uses slice [r*2 +: 2]
q  out  NUM_FF  flop outputs
q_bar  out  NUM_FF  always ~q
grant_valid  out  1  registered; 1 if a command was accepted on the previous edge
grant_id  out  RID_W  registered id of that requester; holds its value when grant_valid=0
err_oob  out  1  one-cycle pulse when an applied command had index >= NUM_FF
op_count  out  16  saturating count of commands applied in range

Interface decision: one clock (clk). Reset (rst_n) is synchronous and active-high. The name follows the codebase; the polarity is as stated.

Behaviour:
- JK encoding: 00 hold, 01 reset (q=0), 10 set (q=1), 11 toggle (q=~q). Flops not addressed in a cycle receive 00.
- Handshake:
  - req_ready is combinational from req_valid and the round-robin pointer ptr. At most one bit is high, and only for a valid requester.
  - A command transfers when req_valid[r] & req_ready[r] at a rising edge.
  - A requester must hold valid, idx and jk stable until accepted. Dropping valid before acceptance is allowed and loses nothing.
- Arbitration:
  - Search starts at ptr and wraps modulo NUM_REQ. The first valid requester is granted.
  - On acceptance of r, ptr <= (r+1) mod NUM_REQ. With no acceptance, ptr holds.
- Pipeline:
  - Edge E0 (accept): the command is latched into cmd_q, and cmd_v <= 1.
  - Edge E1: cmd_q is applied to flop cmd_q.idx. q reflects the result after E1, so latency is 2 edges from accept to q.
  - Throughput is 1 command per cycle. Commands to the same flop apply in acceptance order with no merging.
- grant_valid/grant_id update at E0 together with cmd_q.
- Out-of-range index (idx >= NUM_FF):
  - The command is still accepted.
  - At E1 no flop changes, err_oob=1 for one cycle, and op_count does not increment.
- op_count increments at E1 for each in-range applied command. It saturates at 16'hFFFF and never wraps.
- Reset (rst_n=1 at an edge):
  - q=0, q_bar=all ones, ptr=0, cmd_v=0, grant_valid=0, grant_id=0, err_oob=0, op_count=0.
  - req_ready is forced to 0 while rst_n=1.
  - A command pending in cmd_q is discarded and never applied.
- Reset deasserted: accepting commands may begin on the first edge where rst_n=0.
- All-requesters-valid steady state: grants rotate strictly r, r+1, ... so each requester is accepted once per NUM_REQ cycles.

Decomposition:
- Package jk_bank_pkg holds:
  - typedef enum logic[1:0] jk_cmd_e {JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11}
  - localparam OPCNT_W=16
  - a packed struct jk_cmd_t {idx, cmd}
- Sub-module jk_ff_cell: a single JK flop with clk, synchronous active-high rst, and j/k inputs. Outputs q, q_bar. Instantiated NUM_FF times with a generate loop.
- Arbiter, command register and counters stay in jk_bank_arbiter.

Test Plan:
1. Reset, then release. Requester 0 sends idx=3 jk=10. -> req_ready[0]=1 in the same cycle; grant_valid=1, grant_id=0 after E0; q=8'h08, q_bar=8'hF7 after E1; op_count=1.
2. Requester 1 sends idx=3 jk=11 twice back-to-back (starting with q[3]=1). -> q[3] reads 0 then 1 on consecutive cycles; op_count increases by 2.
3. All 4 requesters hold valid, each targeting a distinct idx 0..3 with jk=10, starting from ptr=0. -> grant_id sequence 0,1,2,3; q=8'h0F after the 4th apply; no requester is granted twice.
4. NUM_FF=6 build: send idx=7 jk=10. -> accepted; err_oob pulses 1 cycle; q unchanged; op_count unchanged.
5. Accept idx=5 jk=10, then assert rst_n=1 on the following edge (E1). -> q stays 0, op_count=0, req_ready=0 during reset; the command is never applied.
6. Preload op_count to 16'hFFFE (force, or a long run) and apply 3 commands. -> op_count holds at 16'hFFFF.
